// File: rtl/depth_sweep_ctrl.sv
// Parses an ASCII decimal stream, counts values that exceed their predecessor,
// and on end-of-input streams the count out as decimal ASCII followed by a newline.
module depth_sweep_ctrl #(
  parameter int          NWIDTH   = 16,
  parameter logic [7:0]  END_BYTE = 8'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] count,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  leds
);

  typedef enum logic [1:0] {S_PARSE, S_CONV, S_SEND, S_NL} state_t;

  state_t              r_state, w_state_next;
  logic [NWIDTH-1:0]   r_cur, w_cur_next;
  logic [NWIDTH-1:0]   r_prev, w_prev_next;
  logic                r_have_digit, w_have_digit_next;
  logic                r_have_prev, w_have_prev_next;
  logic [15:0]         r_count, w_count_next;
  logic [15:0]         r_rem, w_rem_next;
  logic [2:0]          r_pos, w_pos_next;
  logic [3:0]          r_digit, w_digit_next;
  logic                r_started, w_started_next;
  logic [7:0]          r_tx_data, w_tx_data_next;
  logic                r_tx_valid, w_tx_valid_next;
  logic                r_overrun, w_overrun_next;

  logic                w_is_digit;
  logic [NWIDTH-1:0]   w_cur_acc;
  logic                w_inc;
  logic [15:0]         w_count_fin;
  logic [15:0]         w_pow;

  assign w_is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  // cur*10 as shift-add; the low nibble of an ASCII digit is its value
  assign w_cur_acc   = (r_cur << 3) + (r_cur << 1) + NWIDTH'(rx_data[3:0]);
  assign w_inc       = r_have_digit && r_have_prev && (r_cur > r_prev) &&
                       (r_count != 16'hFFFF);
  assign w_count_fin = r_count + 16'(w_inc);

  always_comb begin
    w_pow = 16'd1;
    case (r_pos)
      3'd4:    w_pow = 16'd10000;
      3'd3:    w_pow = 16'd1000;
      3'd2:    w_pow = 16'd100;
      3'd1:    w_pow = 16'd10;
      default: w_pow = 16'd1;
    endcase
  end

  always_comb begin
    w_state_next      = r_state;
    w_cur_next        = r_cur;
    w_prev_next       = r_prev;
    w_have_digit_next = r_have_digit;
    w_have_prev_next  = r_have_prev;
    w_count_next      = r_count;
    w_rem_next        = r_rem;
    w_pos_next        = r_pos;
    w_digit_next      = r_digit;
    w_started_next    = r_started;
    w_tx_data_next    = r_tx_data;
    w_tx_valid_next   = r_tx_valid;
    w_overrun_next    = r_overrun | (rx_valid && (r_state != S_PARSE));

    case (r_state)
      S_PARSE: begin
        if (rx_valid) begin
          if ((rx_data == END_BYTE) || (rx_data == 8'h0A)) begin
            if (r_have_digit) begin
              w_count_next      = w_count_fin;
              w_prev_next       = r_cur;
              w_have_prev_next  = 1'b1;
              w_cur_next        = '0;
              w_have_digit_next = 1'b0;
            end
            if (rx_data == END_BYTE) begin
              // w_count_fin equals r_count when nothing was pending
              w_state_next   = S_CONV;
              w_rem_next     = w_count_fin;
              w_pos_next     = 3'd4;
              w_digit_next   = 4'd0;
              w_started_next = 1'b0;
            end
          end else if (w_is_digit) begin
            w_cur_next        = w_cur_acc;
            w_have_digit_next = 1'b1;
          end
        end
      end

      S_CONV: begin
        if (r_rem >= w_pow) begin
          w_rem_next   = r_rem - w_pow;
          w_digit_next = r_digit + 4'd1;
        end else if ((r_digit != 4'd0) || r_started || (r_pos == 3'd0)) begin
          w_tx_data_next  = 8'h30 | {4'h0, r_digit};
          w_tx_valid_next = 1'b1;
          w_state_next    = S_SEND;
        end else begin
          w_pos_next   = r_pos - 3'd1;
          w_digit_next = 4'd0;
        end
      end

      S_SEND: begin
        if (r_tx_valid && tx_ready) begin
          w_tx_valid_next = 1'b0;
          w_started_next  = 1'b1;
          if (r_pos == 3'd0) begin
            w_state_next = S_NL;
          end else begin
            w_pos_next   = r_pos - 3'd1;
            w_digit_next = 4'd0;
            w_state_next = S_CONV;
          end
        end
      end

      S_NL: begin
        if (!r_tx_valid) begin
          w_tx_data_next  = 8'h0A;
          w_tx_valid_next = 1'b1;
        end else if (tx_ready) begin
          // run complete: forget everything except the sticky overrun flag
          w_tx_valid_next   = 1'b0;
          w_count_next      = 16'd0;
          w_cur_next        = '0;
          w_prev_next       = '0;
          w_have_digit_next = 1'b0;
          w_have_prev_next  = 1'b0;
          w_state_next      = S_PARSE;
        end
      end

      default: w_state_next = S_PARSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_PARSE;
      r_cur        <= '0;
      r_prev       <= '0;
      r_have_digit <= 1'b0;
      r_have_prev  <= 1'b0;
      r_count      <= 16'd0;
      r_rem        <= 16'd0;
      r_pos        <= 3'd0;
      r_digit      <= 4'd0;
      r_started    <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cur        <= w_cur_next;
      r_prev       <= w_prev_next;
      r_have_digit <= w_have_digit_next;
      r_have_prev  <= w_have_prev_next;
      r_count      <= w_count_next;
      r_rem        <= w_rem_next;
      r_pos        <= w_pos_next;
      r_digit      <= w_digit_next;
      r_started    <= w_started_next;
      r_tx_data    <= w_tx_data_next;
      r_tx_valid   <= w_tx_valid_next;
      r_overrun    <= w_overrun_next;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign count    = r_count;
  assign busy     = (r_state != S_PARSE);
  assign overrun  = r_overrun;
  assign leds     = r_count[7:0];

endmodule
